// File: rtl/tinyalu_core.sv
// tinyalu_core: TinyALU datapath and control.
// One operand pair + opcode per start/done handshake. Logical ops finish one
// edge after capture; multiply runs through MUL_LATENCY-1 product registers
// before landing in the result register. done is a registered one-cycle pulse.
module tinyalu_core #(
  parameter int MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_RST = 3'b111;

  // Number of product registers between operand capture and the result flop.
  localparam int         NSTG     = MUL_LATENCY - 1;
  // Counter is 1 right after capture and reaches MUL_LATENCY on the
  // completing edge's preceding cycle.
  localparam logic [2:0] CNT_LAST = 3'(MUL_LATENCY);

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] result_q, result_d;
  logic        done_q, done_d;
  logic [15:0] pipe_q [NSTG];
  logic [15:0] pipe_d [NSTG];
  logic        pipe_en;
  logic [15:0] logic_res;

  logic is_logic_op;
  assign is_logic_op = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: a low start in EXEC/MUL aborts; HOLD waits for start to drop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_logic_op)       state_d = S_EXEC;
          else if (op == OP_MUL) state_d = S_MUL;
          else                   state_d = S_HOLD;
        end
      end
      S_EXEC: state_d = start ? S_HOLD : S_IDLE;
      S_MUL: begin
        if (!start)                state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) state_d = S_HOLD;
      end
      S_HOLD: if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle logical result from the captured operands and opcode.
  always_comb begin
    logic_res = 16'h0000;
    case (op_q)
      OP_ADD:  logic_res = {7'b0, ({1'b0, a_q} + {1'b0, b_q})};
      OP_AND:  logic_res = {8'b0, (a_q & b_q)};
      OP_XOR:  logic_res = {8'b0, (a_q ^ b_q)};
      default: logic_res = 16'h0000;
    endcase
  end

  // FSM outputs: operand capture, stage counter, result and done updates.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_logic_op) begin
            a_d  = A;
            b_d  = B;
            op_d = op;
          end else if (op == OP_MUL) begin
            a_d   = A;
            b_d   = B;
            cnt_d = 3'd1;
          end else if (op == OP_RST) begin
            result_d = 16'h0000;
          end
        end
      end
      S_EXEC: begin
        if (start) begin
          result_d = logic_res;
          done_d   = 1'b1;
        end
      end
      S_MUL: begin
        if (start) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == CNT_LAST) begin
            result_d = pipe_q[NSTG-1];
            done_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears result and done immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      op_q     <= 3'b000;
      cnt_q    <= 3'd0;
      result_q <= 16'h0000;
      done_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Product pipeline: stage 0 multiplies the captured operands, later stages
  // just delay. Only advances while a multiply is in flight.
  assign pipe_en = (state_q == S_MUL);

  always_comb begin
    pipe_d[0] = {8'b0, a_q} * {8'b0, b_q};
    for (int i = 1; i < NSTG; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Product stage registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSTG; i++) pipe_q[i] <= 16'h0000;
    end else if (pipe_en) begin
      for (int i = 0; i < NSTG; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/tinyalu_core.md
# tinyalu_core

- Synthesizable TinyALU datapath and control.
- Accepts one 8-bit operand pair and an opcode per start/done transaction. Returns a 16-bit result with a one-cycle done pulse.
- Sits between the tester/BFM drive side and the scoreboard: the scoreboard samples `result` on the rising edge of `done`.
- Logical ops complete in one cycle. Multiply runs through a registered multi-stage pipeline.

## Interface
Parameters:
- `MUL_LATENCY`, default 3: clock edges from operand capture to multiply done; legal range 2..6.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `A`  in  8  operand A, unsigned
- `B`  in  8  operand B, unsigned
- `op`  in  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 111 rst_op; 101/110 behave as no_op
- `start`  in  1  request; held high by the driver until `done` or until it aborts
- `done`  out  1  one-cycle completion pulse
- `result`  out  16  last completed result; held between operations

## Operation
Reset:
- While `reset_n` is low: state IDLE, `done` = 0, `result` = 16'h0000, pipeline contents invalid.
- Takes effect immediately, independent of `clk`, including mid-operation.

States: IDLE, EXEC, MUL, HOLD.

IDLE (edge with `start` = 1):
- add/and/xor: capture A, B, op; go to EXEC.
- mul: capture A, B; go to MUL with the stage counter at 1.
- rst_op: `result` cleared to 0; go to HOLD; no `done`.
- no_op / 101 / 110: no capture; go to HOLD; `result` unchanged; no `done`.

EXEC:
- Next edge: register the result, assert `done` for that cycle, go to HOLD.

MUL:
- Product propagates through MUL_LATENCY-1 register stages after capture.
- On the edge where the counter reaches MUL_LATENCY: register the product, assert `done`, go to HOLD.

HOLD:
- Stays until an edge samples `start` = 0, then goes to IDLE.
- `start` held high after `done` never launches a second operation.

Abort:
- If `start` is sampled 0 in EXEC or MUL: discard the operation, go to IDLE, no `done`, `result` unchanged.

Arithmetic (operands unsigned, zero-extended):
- add: {7'b0, A+B} (9-bit sum including carry).
- and: {8'b0, A&B}.
- xor: {8'b0, A^B}.
- mul: full 16-bit A*B, no truncation.

Operand handling: A/B/op changes after capture do not affect the in-flight result.

## Timing
- Capture edge = edge k, i.e. the edge at which IDLE samples `start` = 1.
- add/and/xor: `result` updated and `done` = 1 after edge k+1; `done` returns to 0 after edge k+2.
- mul: `result` updated and `done` = 1 after edge k+MUL_LATENCY; one cycle wide.
- `result` is valid in the same cycle `done` is high and stays stable until the next completion, rst_op, or reset.
- `done` is never high two consecutive cycles.
- Minimum spacing between completions: capture, compute, HOLD with `start` low, IDLE — so at least 3 cycles for logical ops.
- rst_op: `result` = 0 after edge k; `done` stays 0.
- Reset asserted in the same cycle as a completing edge: reset wins; `done` = 0, `result` = 0.

## Test plan
- Add, carry case: reset, A=8'hFF, B=8'hFF, op=001, start held → `done` one cycle high exactly 1 edge after capture; `result` = 16'h01FE.
- Mul, full width: A=8'hFF, B=8'hFF, op=100, MUL_LATENCY=3 → `done` 3 edges after capture; `result` = 16'hFE01. Change A/B on the edge after capture → result unchanged.
- and/xor back-to-back: A=8'hA5, B=8'h5A, xor → 16'h00FF. Then start low one cycle, and with same operands → 16'h0000. Exactly two `done` pulses.
- Start held after done: add 8'h01+8'h02 with `start` kept high 10 cycles → single `done`, `result` = 16'h0003. Drop start → IDLE; next request is accepted.
- Abort and rst_op: start a mul, drop `start` after 1 edge → no `done`, `result` keeps its prior value. Then rst_op → `result` = 16'h0000, no `done`.
- Reset mid-operation: assert `reset_n` = 0 between clock edges during MUL stage 2 → `done` = 0 and `result` = 0 immediately. Release → IDLE; a fresh mul 8'h10*8'h10 returns 16'h0100.
